// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, the decoded
// Booth selection and the window decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic single;
    logic double;
    logic neg;
  } booth_sel_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}; 000 and 111 both select zero.
  function automatic booth_sel_t booth_decode(input logic [2:0] window);
    booth_sel_t sel;
    sel.single = window[1] ^ window[0];
    sel.double = (window == 3'b011) || (window == 3'b100);
    sel.neg    = window[2] & ~(window[1] & window[0]);
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: turns one Booth window and the
// multiplicand into a signed WIDTH+2-bit partial product in [-2a, 2a].
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] pp
);

  booth_sel_t       sel;
  logic [WIDTH+1:0] mcand_ext;
  logic [WIDTH+1:0] magnitude;

  // Sign-extend before doubling so 2a keeps its sign bit even for -2^(WIDTH-1).
  always_comb begin
    sel       = booth_decode(window);
    mcand_ext = {{2{mcand[WIDTH-1]}}, mcand};
    magnitude = '0;
    if (sel.single) begin
      magnitude = mcand_ext;
    end else if (sel.double) begin
      magnitude = {mcand_ext[WIDTH:0], 1'b0};
    end
    pp = sel.neg ? -magnitude : magnitude;
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier: one partial product per cycle,
// WIDTH/2 RUN cycles per product, valid/ready on operands and result.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   mplier;
  logic [WIDTH-1:0] mcand;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] upper_sum;
  logic             last_step;

  booth_pp_gen #(
    .WIDTH(WIDTH)
  ) u_pp_gen (
    .window(mplier[2:0]),
    .mcand (mcand),
    .pp    (pp)
  );

  assign last_step = (cnt == CNT_W'(STEPS - 1));

  // The partial product lands on the upper WIDTH+2 bits; the two guard bits
  // keep the running sum exact before each arithmetic shift by two.
  always_comb begin
    upper_sum = acc[ACC_W-1:WIDTH] + pp;
    acc_sum   = {upper_sum, acc[WIDTH-1:0]};
    acc_next  = $signed(acc_sum) >>> 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_valid) next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    if (result_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: start_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        result_valid = 1'b1;
        busy         = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
  end

  // Product is captured on the final RUN edge and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && start_valid) begin
      mcand  <= a;
      mplier <= {b, 1'b0};
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mplier <= mplier >> 2;
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        product <= acc_next[2*WIDTH-1:0];
      end
    end
  end

endmodule
